// File: rtl/lock_ctrl.sv
// -----------------------------------------------------------------------------
// lock_ctrl
//   Consumer of the "110" pattern-unlock detector. It counts key bits per
//   attempt, turns the detector's match pulse into a timed door unlock, and
//   after MAX_FAIL consecutive failed attempts ignores input for a fixed
//   lockout time while raising the alarm line.
//
// Optional feature macro: LOCK_DOOR_SENSE_EN
//   Adds the door_closed input and the door_ajar output. While OPEN, the
//   unlock timer only runs with the door closed. Relock and timeout only take
//   effect with the door closed. door_ajar flags a door held open for
//   OPEN_CYCLES cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset, synchronous release
//   bit_valid    in   one-cycle strobe: a key bit entered the detector
//   match        in   one-cycle detector hit for the "110" pattern
//   relock       in   manual relock request (level)
//   door_closed  in   door position sensor, 1 = closed (macro only)
//   door_ajar    out  door held open too long while OPEN (macro only)
//   unlock       out  door actuator drive, registered
//   alarm        out  high during lockout, registered
//   fail_cnt     out  consecutive failed attempts, saturates at MAX_FAIL
//   state        out  00 LOCKED, 01 OPEN, 10 LOCKOUT
// -----------------------------------------------------------------------------
module lock_ctrl #(
  parameter int FRAME_LEN      = 3,
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bit_valid,
  input  logic                           match,
  input  logic                           relock,
`ifdef LOCK_DOOR_SENSE_EN
  input  logic                           door_closed,
  output logic                           door_ajar,
`endif
  output logic                           unlock,
  output logic                           alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt,
  output logic [1:0]                     state
);

  localparam int FAIL_W    = $clog2(MAX_FAIL + 1);
  localparam int BIT_W     = $clog2(FRAME_LEN + 1);
  localparam int TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'b00,
    ST_OPEN    = 2'b01,
    ST_LOCKOUT = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  state_e              state_r;
  logic                unlock_r;
  logic                alarm_r;
  logic [FAIL_W-1:0]   fail_cnt_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [TIMER_W-1:0]  timer_r;

  logic                door_closed_s;
  logic                frame_done_s;
  logic [FAIL_W-1:0]   fail_next_s;
  logic                open_tmo_s;
  logic                lockout_tmo_s;
  logic                leave_open_s;

`ifdef LOCK_DOOR_SENSE_EN
  assign door_closed_s = door_closed;
`else
  // Without a door sensor the door is treated as permanently closed.
  assign door_closed_s = 1'b1;
`endif

  // Next-state helpers: frame completion, saturating failure count, timeouts.
  always_comb begin
    frame_done_s  = bit_valid && (bit_cnt_r >= BIT_W'(FRAME_LEN - 1));
    if (fail_cnt_r < FAIL_W'(MAX_FAIL)) begin
      fail_next_s = fail_cnt_r + FAIL_W'(1);
    end else begin
      fail_next_s = fail_cnt_r;
    end
    open_tmo_s    = (timer_r == TIMER_W'(OPEN_CYCLES - 1));
    lockout_tmo_s = (timer_r == TIMER_W'(LOCKOUT_CYCLES - 1));
    leave_open_s  = (state_r == ST_OPEN) && (open_tmo_s || relock) && door_closed_s;
  end

  // Main lock FSM; all outputs are held in flops updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_LOCKED;
      unlock_r   <= 1'b0;
      alarm_r    <= 1'b0;
      fail_cnt_r <= '0;
      bit_cnt_r  <= '0;
      timer_r    <= '0;
    end else begin
      case (state_r)
        ST_LOCKED: begin
          // match wins over a frame-completing bit in the same cycle
          if (match) begin
            state_r    <= ST_OPEN;
            unlock_r   <= 1'b1;
            fail_cnt_r <= '0;
            bit_cnt_r  <= '0;
            timer_r    <= '0;
          end else if (frame_done_s) begin
            bit_cnt_r  <= '0;
            fail_cnt_r <= fail_next_s;
            if (fail_next_s == FAIL_W'(MAX_FAIL)) begin
              state_r <= ST_LOCKOUT;
              alarm_r <= 1'b1;
              timer_r <= '0;
            end
          end else if (bit_valid) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end
        end
        ST_OPEN: begin
          // Repeated matches are ignored so they cannot extend the open time.
          if (leave_open_s) begin
            state_r   <= ST_LOCKED;
            unlock_r  <= 1'b0;
            bit_cnt_r <= '0;
            timer_r   <= '0;
          end else if (door_closed_s && !open_tmo_s) begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (lockout_tmo_s) begin
            state_r    <= ST_LOCKED;
            alarm_r    <= 1'b0;
            fail_cnt_r <= '0;
            bit_cnt_r  <= '0;
            timer_r    <= '0;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        default: begin
          // Unused encoding: fall back to the reset picture.
          state_r    <= ST_LOCKED;
          unlock_r   <= 1'b0;
          alarm_r    <= 1'b0;
          fail_cnt_r <= '0;
          bit_cnt_r  <= '0;
          timer_r    <= '0;
        end
      endcase
    end
  end

`ifdef LOCK_DOOR_SENSE_EN
  localparam int AJAR_W = $clog2(OPEN_CYCLES + 1);

  logic [AJAR_W-1:0] ajar_cnt_r;
  logic              door_ajar_r;

  // Counts consecutive open-door cycles while OPEN; the flag sticks until OPEN is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ajar_cnt_r  <= '0;
      door_ajar_r <= 1'b0;
    end else if ((state_r != ST_OPEN) || leave_open_s) begin
      ajar_cnt_r  <= '0;
      door_ajar_r <= 1'b0;
    end else if (!door_closed) begin
      if (ajar_cnt_r < AJAR_W'(OPEN_CYCLES)) begin
        ajar_cnt_r <= ajar_cnt_r + AJAR_W'(1);
      end
      if (ajar_cnt_r >= AJAR_W'(OPEN_CYCLES - 1)) begin
        door_ajar_r <= 1'b1;
      end
    end else begin
      ajar_cnt_r <= '0;
    end
  end

  assign door_ajar = door_ajar_r;
`endif

  assign unlock   = unlock_r;
  assign alarm    = alarm_r;
  assign fail_cnt = fail_cnt_r;
  assign state    = state_r;

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Downstream consumer of the 110 pattern-unlock detector.
- Counts entered bits per attempt and turns the detector's match pulse into a timed unlock.
- After too many failed attempts it locks out input for a fixed time and raises an alarm.
- Drives the door actuator (unlock) and the home-automation alarm line.

Parameters:
- FRAME_LEN, 3: bits per attempt. An attempt fails if no match arrives within this many bits.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- OPEN_CYCLES, 16: clk cycles unlock stays high before auto-relock.
- LOCKOUT_CYCLES, 64: clk cycles input is ignored after MAX_FAIL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Asynchronous, active-low: 0 resets, 1 runs.
- bit_valid  in  1  one-cycle strobe; the same cycle's serial key bit was clocked into the detector.
- match  in  1  detector output. High for one cycle when 110 is recognised, aligned with or one cycle after the completing bit_valid.
- relock  in  1  manual relock request, level-sensitive.
- unlock  out  1  door actuator drive, registered.
- alarm  out  1  high during lockout, registered.
- fail_cnt  out  $clog2(MAX_FAIL+1)  current consecutive failure count.
- state  out  2  00 LOCKED, 01 OPEN, 10 LOCKOUT, 11 unused.

Behaviour:
- Reset (rst=0, async): state=LOCKED, unlock=0, alarm=0, fail_cnt=0, bit counter=0, timer=0. Takes effect immediately, mid-operation included, with no pending action kept. Release is synchronous to clk.
- LOCKED:
  - Each bit_valid increments bit_cnt.
  - match (any cycle) goes to OPEN next cycle: unlock=1, fail_cnt=0, bit_cnt=0, timer=0. Latency from match to unlock is 1 cycle.
  - Otherwise, a bit_valid that brings bit_cnt to FRAME_LEN is a failure: bit_cnt=0, fail_cnt+1.
  - If the new fail_cnt equals MAX_FAIL, go to LOCKOUT: alarm=1, timer=0.
  - match and a frame-completing bit_valid in the same cycle count as success; match has priority.
- OPEN:
  - Timer increments every cycle.
  - At timer==OPEN_CYCLES-1, or relock=1, go to LOCKED next cycle: unlock=0, bit_cnt=0.
  - bit_valid and match are ignored. A repeated match does not restart the timer.
- LOCKOUT:
  - bit_valid, match and relock are ignored.
  - Timer increments. At timer==LOCKOUT_CYCLES-1, go to LOCKED: alarm=0, fail_cnt=0, bit_cnt=0.
- Illegal state 11: recovers to LOCKED next cycle with all outputs as at reset.
- Arithmetic:
  - Timer width is $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)).
  - Counters saturate and never wrap: fail_cnt never exceeds MAX_FAIL, bit_cnt never exceeds FRAME_LEN-1 at rest.
- All outputs come directly from flops. No combinational path from inputs to outputs.

Optional Feature:
- Macro: LOCK_DOOR_SENSE_EN.
- With the macro defined:
  - Adds input door_closed (1 bit).
  - In OPEN, the timer advances only while door_closed=1 and is held while the door is open.
  - relock and timeout return to LOCKED only when door_closed=1; otherwise the state stays OPEN with unlock=1.
  - An extra output door_ajar (1 bit, registered, reset 0) goes high if the door stays open ≥ OPEN_CYCLES cycles in OPEN, and clears on leaving OPEN.
- Without the macro: no door_closed or door_ajar ports, and behaviour is exactly as above.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1, with no inputs for 10 cycles → unlock=0, alarm=0, fail_cnt=0, state=00 throughout. Assert rst=0 mid-OPEN → unlock drops the same cycle.
- Good entry: three bit_valid strobes, then match on the third → unlock=1 one cycle later. unlock stays high exactly 16 cycles, then state=00.
- Manual relock: enter OPEN, assert relock at OPEN cycle 5 → unlock=0 on the next cycle, with bit_cnt cleared.
- Lockout: 9 bit_valid strobes with no match → fail_cnt goes 1, 2, 3. On the 9th strobe alarm=1 next cycle and state=10. During the 64 LOCKOUT cycles a match gives no unlock. After 64 cycles alarm=0, fail_cnt=0.
- Recovery: 2 failed frames (fail_cnt=2), then a match → unlock=1, fail_cnt=0. Match in the same cycle as a 3rd frame-completing bit_valid → success, not lockout.
- LOCK_DOOR_SENSE_EN: in OPEN with door_closed=0 for 20 cycles → unlock stays 1 and door_ajar=1 after 16 cycles. Then door_closed=1 → timer resumes, relock after 16 more cycles and door_ajar=0.
